mult_operand_feeder: RTL and testbench

- Upstream/downstream companion to the shift-add multiplier (sequencer plus datapath).
- Buffers operand pairs from a producer in a small FIFO and presents each pair on the multiplier's operand inputs.
- Pulses the multiplier's start input, waits for its ready, captures the product into an output register and hands it on with valid/ready.
- Serialises back-to-back multiplications with no software involvement.

---
 rtl/mult_operand_feeder.sv | 166 ++++++++++++++++
 tb/tb_mult_operand_feeder.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_operand_feeder.sv
// Operand FIFO and sequencing front-end for a shift-add multiplier.
// Optional two's-complement operation is enabled by defining SIGNED_EN.
module mult_operand_feeder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         feedreset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_a,
  input  logic [WIDTH-1:0]             in_b,
  output logic [WIDTH-1:0]             mult_m,
  output logic [WIDTH-1:0]             mult_q,
  output logic                         mult_start,
  input  logic                         mult_ready,
  input  logic [2*WIDTH-1:0]           mult_product,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2*WIDTH-1:0]           out_product,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StArm,
    StWait
  } state_t;

  logic [WIDTH-1:0]   r_mem_a [DEPTH];
  logic [WIDTH-1:0]   r_mem_b [DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;

  state_t             r_state;
  logic [WIDTH-1:0]   r_mult_m;
  logic [WIDTH-1:0]   r_mult_q;
  logic               r_start;
  logic               r_busy;
  logic               r_out_valid;
  logic [2*WIDTH-1:0] r_out_product;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_capture;
  logic [WIDTH-1:0]   w_head_a;
  logic [WIDTH-1:0]   w_head_b;
  logic [WIDTH-1:0]   w_op_m;
  logic [WIDTH-1:0]   w_op_q;
  logic [2*WIDTH-1:0] w_result;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  // Full stays full for the whole cycle: a concurrent pop never opens a slot.
  assign w_push    = in_valid && !w_full;
  assign w_pop     = (r_state == StIdle) && !w_empty;
  assign w_capture = (r_state == StWait) && mult_ready && (!r_out_valid || out_ready);
  assign w_head_a  = r_mem_a[r_rd_ptr];
  assign w_head_b  = r_mem_b[r_rd_ptr];

`ifdef SIGNED_EN
  logic r_neg;

  // Magnitude in WIDTH bits; the most negative value maps onto 2^(WIDTH-1).
  assign w_op_m   = w_head_a[WIDTH-1] ? (~w_head_a + WIDTH'(1)) : w_head_a;
  assign w_op_q   = w_head_b[WIDTH-1] ? (~w_head_b + WIDTH'(1)) : w_head_b;
  assign w_result = r_neg ? (~mult_product + (2*WIDTH)'(1)) : mult_product;

  always_ff @(posedge clock or posedge feedreset) begin
    if (feedreset) begin
      r_neg <= 1'b0;
    end else if (w_pop) begin
      r_neg <= w_head_a[WIDTH-1] ^ w_head_b[WIDTH-1];
    end
  end
`else
  assign w_op_m   = w_head_a;
  assign w_op_q   = w_head_b;
  assign w_result = mult_product;
`endif

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr] <= in_a;
      r_mem_b[r_wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clock or posedge feedreset) begin
    if (feedreset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge feedreset) begin
    if (feedreset) begin
      r_state       <= StIdle;
      r_mult_m      <= '0;
      r_mult_q      <= '0;
      r_start       <= 1'b0;
      r_busy        <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_product <= '0;
    end else begin
      r_start <= 1'b0;
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_mult_m <= w_op_m;
            r_mult_q <= w_op_q;
            r_start  <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= StIssue;
          end
        end
        StIssue: r_state <= StArm;
        // mult_ready may still be high from the previous run here.
        StArm:   r_state <= StWait;
        StWait: begin
          if (w_capture) begin
            r_out_product <= w_result;
            r_out_valid   <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready    = !w_full;
  assign mult_m      = r_mult_m;
  assign mult_q      = r_mult_q;
  assign mult_start  = r_start;
  assign out_valid   = r_out_valid;
  assign out_product = r_out_product;
  assign busy        = r_busy;
  assign fifo_count  = r_count;

endmodule

// File: tb/tb_mult_operand_feeder.sv
// Self-checking bench for mult_operand_feeder with a behavioural multiplier
// model and a product reference computed from the operand values.
module tb_mult_operand_feeder;
  localparam int W = 8;
  localparam int D = 4;

  logic           clock = 1'b0;
  logic           feedreset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a, in_b;
  logic [W-1:0]   mult_m, mult_q;
  logic           mult_start;
  logic           mult_ready;
  logic [2*W-1:0] mult_product;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_product;
  logic           busy;
  logic [2:0]     fifo_count;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  logic [2*W-1:0] obs_q[$];

  bit hold = 1'b0;
  bit rand_lat = 1'b0;
  int lat = 18;
  int m_cnt;
  logic [2*W-1:0] m_a, m_b;

  mult_operand_feeder #(.WIDTH(W), .DEPTH(D)) dut (
    .clock(clock), .feedreset(feedreset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mult_m(mult_m), .mult_q(mult_q),
    .mult_start(mult_start), .mult_ready(mult_ready), .mult_product(mult_product),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  // Multiplier stand-in: ready drops on start, product appears lat cycles later.
  always @(posedge clock or posedge feedreset) begin
    if (feedreset) begin
      mult_ready   <= 1'b1;
      mult_product <= '0;
      m_cnt        <= 0;
      m_a          <= '0;
      m_b          <= '0;
    end else if (mult_start) begin
      mult_ready   <= 1'b0;
      mult_product <= '0;
      m_cnt        <= rand_lat ? int'($urandom_range(1, 20)) : lat;
      m_a          <= {8'd0, mult_m};
      m_b          <= {8'd0, mult_q};
    end else if (!mult_ready && !hold) begin
      if (m_cnt <= 1) begin
        mult_ready   <= 1'b1;
        mult_product <= m_a * m_b;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(posedge clock) begin
    if (mult_start) start_cnt <= start_cnt + 1;
    if (out_valid && out_ready) obs_q.push_back(out_product);
  end

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    int x, y;
`ifdef SIGNED_EN
    x = int'($signed(a));
    y = int'($signed(b));
`else
    x = int'(a);
    y = int'(b);
`endif
    return 16'(x * y);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: in_ready=%0b after %0d cycles, need 1", in_ready, n);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_obs(input int target, input int budget);
    int n = 0;
    while (obs_q.size() < target && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    feedreset = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    tick();
    tick();
    checks++;
    if ({mult_m, mult_q, mult_start, out_valid, out_product, busy, fifo_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: m=%0h q=%0h st=%0b ov=%0b p=%0h busy=%0b cnt=%0d, need all 0",
               mult_m, mult_q, mult_start, out_valid, out_product, busy, fifo_count);
    end
    feedreset = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b need 1", in_ready);
    end
  endtask

  task automatic test_single();
    int s0 = start_cnt;
    int base = obs_q.size();
    int n = 0;
    out_ready = 1'b0;
    in_a = 8'd13;
    in_b = 8'd11;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (mult_start !== 1'b0) begin
      errors++;
      $display("FAIL single_early_start: mult_start=%0b need 0", mult_start);
    end
    tick();
    checks++;
    if ({mult_start, mult_m, mult_q, busy} !== {1'b1, 8'd13, 8'd11, 1'b1}) begin
      errors++;
      $display("FAIL single_issue: st=%0b m=%0d q=%0d busy=%0b need 1,13,11,1",
               mult_start, mult_m, mult_q, busy);
    end
    while (!out_valid && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if ({out_valid, out_product, busy} !== {1'b1, 16'd143, 1'b0}) begin
      errors++;
      $display("FAIL single_result: ov=%0b p=%0d busy=%0b need 1,143,0", out_valid, out_product,
               busy);
    end
    checks++;
    if (start_cnt - s0 !== 1) begin
      errors++;
      $display("FAIL single_start_count: got %0d need 1", start_cnt - s0);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || obs_q.size() !== base + 1) begin
      errors++;
      $display("FAIL single_drain: ov=%0b taken=%0d need 0,1", out_valid, obs_q.size() - base);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] va[4] = '{8'd255, 8'd0, 8'd1, 8'd128};
    logic [W-1:0] vb[4] = '{8'd255, 8'd77, 8'd200, 8'd2};
    int s0 = start_cnt;
    int base = obs_q.size();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(va[i], vb[i]);
    wait_obs(base + 4, 400);
    repeat (5) tick();
    checks++;
    if (obs_q.size() !== base + 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d need 4", obs_q.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_q[base+i] !== ref_prod(va[i], vb[i])) begin
          errors++;
          $display("FAIL b2b_product[%0d]: got %0d need %0d", i, obs_q[base+i],
                   ref_prod(va[i], vb[i]));
        end
      end
    end
    checks++;
    if (start_cnt - s0 !== 4) begin
      errors++;
      $display("FAIL b2b_start_count: got %0d need 4", start_cnt - s0);
    end
  endtask

  task automatic test_full();
    logic [W-1:0] va[6], vb[6];
    int base = obs_q.size();
    bit leaked = 1'b0;
    int n = 0;
    for (int i = 0; i < 6; i++) begin
      va[i] = W'($urandom);
      vb[i] = W'($urandom);
    end
    out_ready = 1'b1;
    hold = 1'b1;
    for (int i = 0; i < 5; i++) push(va[i], vb[i]);
    in_a = va[5];
    in_b = vb[5];
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (in_ready) leaked = 1'b1;
      tick();
    end
    checks++;
    if ({leaked, in_ready, fifo_count, busy} !== {1'b0, 1'b0, 3'd4, 1'b1}) begin
      errors++;
      $display("FAIL full_block: leaked=%0b in_ready=%0b cnt=%0d busy=%0b need 0,0,4,1",
               leaked, in_ready, fifo_count, busy);
    end
    hold = 1'b0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
    wait_obs(base + 6, 600);
    checks++;
    if (obs_q.size() !== base + 6) begin
      errors++;
      $display("FAIL full_count: got %0d need 6", obs_q.size() - base);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (obs_q[base+i] !== ref_prod(va[i], vb[i])) begin
          errors++;
          $display("FAIL full_product[%0d]: got %0h need %0h", i, obs_q[base+i],
                   ref_prod(va[i], vb[i]));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a0 = W'($urandom), b0 = W'($urandom), a1 = W'($urandom), b1 = W'($urandom);
    logic [2*W-1:0] held;
    int base = obs_q.size();
    int n = 0;
    bit stable = 1'b1;
    out_ready = 1'b0;
    push(a0, b0);
    push(a1, b1);
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    held = out_product;
    checks++;
    if (out_valid !== 1'b1 || held !== ref_prod(a0, b0)) begin
      errors++;
      $display("FAIL bp_first: ov=%0b p=%0h need 1,%0h", out_valid, held, ref_prod(a0, b0));
    end
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!out_valid || out_product !== held) stable = 1'b0;
    end
    checks++;
    if ({stable, busy, fifo_count} !== {1'b1, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL bp_hold: stable=%0b busy=%0b cnt=%0d need 1,1,0", stable, busy, fifo_count);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (obs_q.size() !== base + 1 || out_valid !== 1'b1 || out_product !== ref_prod(a1, b1)) begin
      errors++;
      $display("FAIL bp_second: taken=%0d ov=%0b p=%0h need 1,1,%0h", obs_q.size() - base,
               out_valid, out_product, ref_prod(a1, b1));
    end
    tick();
    checks++;
    if (obs_q.size() !== base + 2 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: taken=%0d ov=%0b need 2,0", obs_q.size() - base, out_valid);
    end else if (obs_q[base] !== ref_prod(a0, b0) || obs_q[base+1] !== ref_prod(a1, b1)) begin
      errors++;
      $display("FAIL bp_order: got %0h,%0h need %0h,%0h", obs_q[base], obs_q[base+1],
               ref_prod(a0, b0), ref_prod(a1, b1));
    end
  endtask

  task automatic test_reset_mid();
    int base;
    int s0;
    out_ready = 1'b1;
    hold = 1'b1;
    push(8'd21, 8'd3);
    push(8'd40, 8'd5);
    push(8'd99, 8'd2);
    repeat (6) tick();
    checks++;
    if (fifo_count !== 3'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: cnt=%0d busy=%0b need 2,1", fifo_count, busy);
    end
    base = obs_q.size();
    feedreset = 1'b1;
    #1;
    checks++;
    if ({mult_m, mult_q, mult_start, out_valid, out_product, busy, fifo_count} !== '0) begin
      errors++;
      $display("FAIL rst_mid_clear: m=%0h q=%0h st=%0b ov=%0b p=%0h busy=%0b cnt=%0d, need 0",
               mult_m, mult_q, mult_start, out_valid, out_product, busy, fifo_count);
    end
    tick();
    feedreset = 1'b0;
    hold = 1'b0;
    s0 = start_cnt;
    push(8'd9, 8'd7);
    wait_obs(base + 1, 100);
    repeat (4) tick();
    checks++;
    if (obs_q.size() !== base + 1 || start_cnt - s0 !== 1) begin
      errors++;
      $display("FAIL rst_mid_after: outputs=%0d starts=%0d need 1,1", obs_q.size() - base,
               start_cnt - s0);
    end else if (obs_q[base] !== ref_prod(8'd9, 8'd7)) begin
      errors++;
      $display("FAIL rst_mid_product: got %0h need %0h", obs_q[base], ref_prod(8'd9, 8'd7));
    end
  endtask

`ifdef SIGNED_EN
  task automatic test_signed();
    logic [W-1:0] va[4] = '{8'h80, 8'hFD, 8'd5, 8'd0};
    logic [W-1:0] vb[4] = '{8'h80, 8'd7, 8'hFF, 8'h80};
    logic [2*W-1:0] ex[4] = '{16'd16384, 16'hFFEB, 16'hFFFB, 16'h0000};
    int base = obs_q.size();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(va[i], vb[i]);
    wait_obs(base + 4, 400);
    checks++;
    if (obs_q.size() !== base + 4) begin
      errors++;
      $display("FAIL signed_count: got %0d need 4", obs_q.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_q[base+i] !== ex[i]) begin
          errors++;
          $display("FAIL signed_product[%0d]: got %0h need %0h", i, obs_q[base+i], ex[i]);
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    localparam int N = 24;
    logic [2*W-1:0] exp_q[$];
    int base = obs_q.size();
    int sent = 0;
    int n = 0;
    logic acc_ready = 1'b0;
    rand_lat = 1'b1;
    in_valid = 1'b0;
    while (obs_q.size() < base + N && n < 3000) begin
      tick();
      n++;
      if (in_valid && acc_ready) begin
        exp_q.push_back(ref_prod(in_a, in_b));
        sent++;
        in_valid = 1'b0;
      end
      if (!in_valid && sent < N && $urandom_range(0, 3) != 0) begin
        in_a = W'($urandom);
        in_b = W'($urandom);
        in_valid = 1'b1;
      end
      out_ready = 1'($urandom_range(0, 1));
      acc_ready = in_ready;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    rand_lat = 1'b0;
    checks++;
    if (obs_q.size() !== base + N || exp_q.size() !== N) begin
      errors++;
      $display("FAIL rand_count: got %0d outputs for %0d pushes, need %0d", obs_q.size() - base,
               exp_q.size(), N);
    end else begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (obs_q[base+i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand_product[%0d]: got %0h need %0h", i, obs_q[base+i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_backpressure();
    test_reset_mid();
`ifdef SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
